dmem_arbiter: RTL

Shares the single data-memory port between the pipeline's memory-access stage and an auxiliary requester (debug/DMA/loader port). The pipeline has priority. A bounded-starvation counter forces one aux access per STARVE_LIMIT blocked cycles, and the arbiter stalls the pipeline for that cycle. The block sits between the MA stage and the data memory (D_MEM) and drives D_MEM's MEMR/MEMW/address/write-data pins.

---
 rtl/dmem_arbiter.sv | 109 ++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the MA pipeline stage and an aux requester.
// The pipeline has priority; a starvation counter forces one aux access per STARVE_LIMIT blocked cycles.
module dmem_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] pipe_ins,
   input  logic [15:0] pipe_addr,
   input  logic [15:0] pipe_wdata,
   output logic [15:0] pipe_rdata,
   output logic        pipe_stall,
   input  logic        aux_req,
   input  logic        aux_we,
   input  logic [15:0] aux_addr,
   input  logic [15:0] aux_wdata,
   output logic        aux_gnt,
   output logic [15:0] aux_rdata,
   output logic        aux_rvalid,
   output logic        mem_r,
   output logic        mem_w,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   output logic [7:0]  stall_cnt
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   typedef enum logic {ST_IDLE, ST_WAIT} st_e;

   st_e         st_q, st_d;
   logic [3:0]  starve_q, starve_d;
   logic [15:0] aux_rdata_q, aux_rdata_d;
   logic        aux_rvalid_q, aux_rvalid_d;
   logic [7:0]  stall_cnt_q, stall_cnt_d;

   logic pipe_load, pipe_store, pipe_acc, gnt, stall;

   assign pipe_load  = (pipe_ins[15:12] == 4'b0111);
   assign pipe_store = (pipe_ins[15:12] == 4'b1000);
   assign pipe_acc   = pipe_load | pipe_store;
   // rst_n gates the grant so every port-side output is quiet during reset.
   assign gnt        = rst_n & aux_req & (~pipe_acc | (starve_q == LIMIT));
   assign stall      = gnt & pipe_acc;

   always_comb begin
      mem_r      = 1'b0;
      mem_w      = 1'b0;
      mem_addr   = 16'h0000;
      mem_wdata  = 16'h0000;
      pipe_rdata = 16'h0000;
      if (rst_n) begin
         if (gnt) begin
            mem_r     = ~aux_we;
            mem_w     = aux_we;
            mem_addr  = aux_addr;
            mem_wdata = aux_wdata;
         end else begin
            mem_r      = pipe_load;
            mem_w      = pipe_store;
            mem_addr   = pipe_addr;
            mem_wdata  = pipe_wdata;
            pipe_rdata = pipe_load ? mem_rdata : 16'h0000;
         end
      end
   end

   always_comb begin
      st_d         = st_q;
      starve_d     = starve_q;
      aux_rvalid_d = gnt & ~aux_we;
      aux_rdata_d  = (gnt & ~aux_we) ? mem_rdata : aux_rdata_q;
      stall_cnt_d  = (stall && stall_cnt_q != 8'hFF) ? stall_cnt_q + 8'd1 : stall_cnt_q;
      if (!aux_req || gnt) begin
         st_d     = ST_IDLE;
         starve_d = 4'd0;
      end else begin
         st_d = ST_WAIT;
         if (st_q == ST_IDLE)
            starve_d = 4'd1;
         else if (starve_q != LIMIT)
            starve_d = starve_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q         <= ST_IDLE;
         starve_q     <= 4'd0;
         aux_rdata_q  <= 16'h0000;
         aux_rvalid_q <= 1'b0;
         stall_cnt_q  <= 8'd0;
      end else begin
         st_q         <= st_d;
         starve_q     <= starve_d;
         aux_rdata_q  <= aux_rdata_d;
         aux_rvalid_q <= aux_rvalid_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   assign aux_gnt    = gnt;
   assign pipe_stall = stall;
   assign aux_rdata  = aux_rdata_q;
   assign aux_rvalid = aux_rvalid_q;
   assign stall_cnt  = stall_cnt_q;

endmodule
